// File: rtl/or32_uart.sv
// Memory-mapped 8N1 UART slave for the or32 core bus: DATA/STATUS/BAUD registers,
// TX and RX FIFOs, and bit-level TX/RX state machines sharing one baud divisor.
module or32_uart #(
    parameter int DEFAULT_DIV = 868,
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_dat_w,
    input  logic [3:0]  i_we,
    input  logic        i_stb,
    output logic [31:0] o_dat_r,
    output logic        o_ack,
    output logic        o_tx,
    input  logic        i_rx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    uart_state_t tx_state, rx_state;
    logic [DIV_W-1:0] baud, div_eff;
    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic [7:0]       tx_shift, rx_shift;
    logic [2:0]       tx_bit, rx_bit;
    logic [DIV_W-1:0] tx_cnt, tx_len, rx_cnt, rx_len;
    logic             rx_s1, rx_s2, rx_prev;
    logic             overrun, frame_err;
    logic [1:0]       sel;
    logic             acc_rd, tx_push, tx_pop, rx_push, rx_pop, stat_rd;
    logic             tx_full, tx_idle, tx_bit_end, rx_stop_sample;
    logic             overrun_set, frame_set;
    logic [31:0]      rd_data;
    logic             unused;

    assign unused  = ^{i_addr[1:0], i_dat_w[31:16]};
    assign sel     = i_addr[3:2];
    assign acc_rd  = i_stb && (i_we == 4'b0000);
    assign div_eff = (baud < DIV_W'(4)) ? DIV_W'(4) : baud;

    assign tx_full    = (tx_count == FULL_CNT);
    assign tx_idle    = (tx_count == '0) && (tx_state == IDLE);
    assign tx_bit_end = (tx_cnt == tx_len - 1'b1);
    assign tx_push    = i_stb && (sel == 2'd0) && i_we[0] && !tx_full;
    // Popping straight out of STOP keeps back-to-back frames exactly 10 bit periods apart.
    assign tx_pop     = (tx_count != '0) &&
                        ((tx_state == IDLE) || (tx_state == STOP && tx_bit_end));

    assign rx_stop_sample = (rx_state == STOP) && (rx_cnt == rx_len - 1'b1);
    assign rx_push     = rx_stop_sample && rx_s2 && (rx_count != FULL_CNT);
    assign overrun_set = rx_stop_sample && rx_s2 && (rx_count == FULL_CNT);
    assign frame_set   = rx_stop_sample && !rx_s2;
    assign rx_pop      = acc_rd && (sel == 2'd0) && (rx_count != '0);
    assign stat_rd     = acc_rd && (sel == 2'd1);

    always_comb begin
        rd_data = 32'd0;
        case (sel)
            2'd0: if (rx_count != '0) rd_data = {24'd0, rx_mem[rx_rd]};
            2'd1: rd_data = {27'd0, frame_err, overrun, tx_idle, tx_full, rx_count != '0};
            2'd2: rd_data = 32'(baud);
            default: rd_data = 32'd0;
        endcase
    end

    // Bus side: ack, read data, BAUD register and sticky error flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ack     <= 1'b0;
            o_dat_r   <= 32'd0;
            baud      <= DIV_W'(DEFAULT_DIV);
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            o_ack <= i_stb;
            if (i_stb) o_dat_r <= acc_rd ? rd_data : 32'd0;
            if (i_stb && sel == 2'd2) begin
                for (int i = 0; i < DIV_W; i++)
                    if (i_we[i/8]) baud[i] <= i_dat_w[i];
            end
            overrun   <= (overrun & ~stat_rd) | overrun_set;
            frame_err <= (frame_err & ~stat_rd) | frame_set;
        end
    end

    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[tx_wr] <= i_dat_w[7:0];
        if (rx_push) rx_mem[rx_wr] <= rx_shift;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_wr <= '0; tx_rd <= '0; tx_count <= '0;
            rx_wr <= '0; rx_rd <= '0; rx_count <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: ;
            endcase
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: ;
            endcase
        end
    end

    // TX: bit length is latched at each bit start so BAUD changes land on the next bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state <= IDLE;
            o_tx     <= 1'b1;
            tx_shift <= 8'd0;
            tx_bit   <= 3'd0;
            tx_cnt   <= '0;
            tx_len   <= DIV_W'(DEFAULT_DIV);
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
            case (tx_state)
                IDLE, STOP: begin
                    if (tx_state == IDLE || tx_bit_end) begin
                        tx_state <= IDLE;
                        if (tx_pop) begin
                            tx_shift <= tx_mem[tx_rd];
                            tx_state <= START;
                            o_tx     <= 1'b0;
                            tx_cnt   <= '0;
                            tx_len   <= div_eff;
                        end
                    end
                end
                START, DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        tx_len <= div_eff;
                        if (tx_state == DATA && tx_bit == 3'd7) begin
                            tx_state <= STOP;
                            o_tx     <= 1'b1;
                        end else begin
                            tx_bit   <= (tx_state == START) ? 3'd0 : tx_bit + 1'b1;
                            tx_state <= DATA;
                            o_tx     <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // RX: start is re-checked half a bit after the synchronized falling edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_shift <= 8'd0;
            rx_bit   <= 3'd0;
            rx_cnt   <= '0;
            rx_len   <= DIV_W'(DEFAULT_DIV);
        end else begin
            rx_s1   <= i_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_cnt  <= rx_cnt + 1'b1;
            case (rx_state)
                IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= START;
                        rx_cnt   <= '0;
                        rx_len   <= div_eff >> 1;
                    end
                end
                START: begin
                    if (rx_cnt == rx_len - 1'b1) begin
                        rx_state <= rx_s2 ? IDLE : DATA;
                        rx_cnt   <= '0;
                        rx_len   <= div_eff;
                        rx_bit   <= 3'd0;
                    end
                end
                DATA: begin
                    if (rx_cnt == rx_len - 1'b1) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= '0;
                        rx_len   <= div_eff;
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= STOP;
                    end
                end
                STOP: begin
                    if (rx_stop_sample) rx_state <= IDLE;
                end
                default: rx_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_or32_uart.sv
// Directed bench for or32_uart: register access, TX framing, loopback RX,
// FIFO overflow on both sides, framing error, glitch rejection and reset mid-frame.
module tb_or32_uart;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] dat_w = 32'd0;
    logic [3:0]  we = 4'd0;
    logic        stb = 1'b0;
    logic [31:0] dat_r;
    logic        ack;
    logic        tx;
    logic        rx;
    logic        loop_en = 1'b0;
    logic        rx_drv = 1'b1;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_BAUD = 4'h8;

    assign rx = loop_en ? tx : rx_drv;

    or32_uart dut (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_dat_w(dat_w), .i_we(we),
        .i_stb(stb), .o_dat_r(dat_r), .o_ack(ack), .o_tx(tx), .i_rx(rx)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // acked is true only when ack was low at strobe time and high one cycle later.
    task automatic bus_xfer(input logic [3:0] a, input logic [31:0] d, input logic [3:0] w,
                            output logic [31:0] rdata, output bit acked);
        bit pre_ok;
        @(posedge clk); #1;
        pre_ok = (ack === 1'b0);
        addr = a; dat_w = d; we = w; stb = 1'b1;
        @(posedge clk); #1;
        acked = pre_ok && (ack === 1'b1);
        rdata = dat_r;
        stb = 1'b0; we = 4'd0;
    endtask

    task automatic get_tx_frame(input int budget, output bit found,
                                output logic [7:0] b, output logic stop);
        found = 0; b = 8'd0; stop = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (tx === 1'b0) begin found = 1; break; end
        end
        if (found) begin
            repeat (6) @(posedge clk);
            #1; b[0] = tx;
            for (int k = 1; k < 8; k++) begin
                repeat (4) @(posedge clk);
                #1; b[k] = tx;
            end
            repeat (4) @(posedge clk);
            #1; stop = tx;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            repeat (4) begin @(posedge clk); #1; end
        end
        rx_drv = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        logic [31:0] r; bit acked;
        rst = 1'b0; #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx !== 1'b1 || ack !== 1'b0 || dat_r !== 32'd0) begin
            bad++; $display("FAIL reset_outputs: tx=%b ack=%b dat_r=%h want 1 0 0", tx, ack, dat_r);
        end
        rst = 1'b0;
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (!acked || r !== 32'h4) begin
            bad++; $display("FAIL reset_status: acked=%0d got=%h want 00000004", acked, r);
        end
        @(posedge clk); #1;
        total++; if (ack !== 1'b0) begin
            bad++; $display("FAIL ack_width: ack=%b want 0 two cycles after stb", ack);
        end
        bus_xfer(A_BAUD, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'd868) begin
            bad++; $display("FAIL reset_baud: got=%0d want 868", r);
        end
    endtask

    task automatic test_tx_frame;
        logic [31:0] r; bit acked; bit found;
        logic [9:0] frame; logic [9:0] bit_err;
        frame = {1'b1, 8'h55, 1'b0};
        bit_err = '0;
        bus_xfer(A_BAUD, 32'h0000_0004, 4'b0011, r, acked);
        bus_xfer(A_BAUD, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'd4) begin
            bad++; $display("FAIL baud_rw: got=%0d want 4", r);
        end
        bus_xfer(A_DATA, 32'h0000_0055, 4'b0001, r, acked);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (tx === 1'b0) begin found = 1; break; end
        end
        total++; if (!found) begin
            bad++; $display("FAIL tx_start: no start bit got tx=%b want 0", tx);
        end else begin
            for (int c = 0; c < 40; c++) begin
                if (c > 0) begin @(posedge clk); #1; end
                if (tx !== frame[c/4]) bit_err[c/4] = 1'b1;
            end
            for (int b = 0; b < 10; b++) begin
                total++; if (bit_err[b]) begin
                    bad++; $display("FAIL tx_bit%0d: got wrong level want %b for 4 clocks", b, frame[b]);
                end
            end
            @(posedge clk); #1;
            total++; if (tx !== 1'b1) begin
                bad++; $display("FAIL tx_after_frame: tx=%b want 1", tx);
            end
        end
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'h4) begin
            bad++; $display("FAIL tx_idle_again: got=%h want 00000004", r);
        end
    endtask

    task automatic test_loopback;
        logic [31:0] r; bit acked;
        loop_en = 1'b1;
        bus_xfer(A_DATA, 32'h0000_00A3, 4'b0001, r, acked);
        repeat (70) @(posedge clk);
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'h5) begin
            bad++; $display("FAIL loop_status1: got=%h want 00000005", r);
        end
        bus_xfer(A_DATA, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'h0000_00A3) begin
            bad++; $display("FAIL loop_data: got=%h want 000000a3", r);
        end
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'h4) begin
            bad++; $display("FAIL loop_status2: got=%h want 00000004", r);
        end
        bus_xfer(A_DATA, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'd0) begin
            bad++; $display("FAIL loop_empty_read: got=%h want 00000000", r);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        int acks; int frames;
        exp_q.delete();
        for (int k = 0; k < 17; k++) exp_q.push_back(8'(8'h10 + k));
        acks = 0; frames = 0;
        fork
            begin
                logic [31:0] r; bit acked;
                for (int k = 0; k < 18; k++) begin
                    bus_xfer(A_DATA, 32'(8'h10 + k), 4'b0001, r, acked);
                    if (acked) acks++;
                end
                bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
                total++; if (r !== 32'h2) begin
                    bad++; $display("FAIL tx_full_status: got=%h want 00000002", r);
                end
            end
            begin
                bit found; logic [7:0] b; logic stop; logic [7:0] e;
                for (int f = 0; f < 18; f++) begin
                    get_tx_frame(100, found, b, stop);
                    if (!found) break;
                    frames++;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    total++; if (b !== e || stop !== 1'b1) begin
                        bad++; $display("FAIL tx_frame%0d: got=%h stop=%b want %h stop=1", f, b, stop, e);
                    end
                end
            end
        join
        total++; if (acks != 18) begin
            bad++; $display("FAIL b2b_acks: got=%0d want 18", acks);
        end
        total++; if (frames != 17) begin
            bad++; $display("FAIL b2b_frames: got=%0d want 17", frames);
        end
    endtask

    task automatic test_rx_overrun;
        logic [31:0] r; bit acked; logic [7:0] b; logic [7:0] e;
        exp_q.delete();
        for (int k = 0; k < 17; k++) begin
            b = 8'(k * 37 + 5);
            if (k < 16) exp_q.push_back(b);
            send_rx(b, 1'b1);
        end
        repeat (20) @(posedge clk);
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'hD) begin
            bad++; $display("FAIL overrun_status1: got=%h want 0000000d", r);
        end
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'h5) begin
            bad++; $display("FAIL overrun_status2: got=%h want 00000005", r);
        end
        for (int k = 0; k < 16; k++) begin
            e = exp_q.pop_front();
            bus_xfer(A_DATA, 32'd0, 4'd0, r, acked);
            total++; if (r !== {24'd0, e}) begin
                bad++; $display("FAIL rx_byte%0d: got=%h want %h", k, r, e);
            end
        end
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'h4) begin
            bad++; $display("FAIL rx_drained: got=%h want 00000004", r);
        end
    endtask

    task automatic test_frame_glitch;
        logic [31:0] r; bit acked;
        send_rx(8'h5A, 1'b0);
        repeat (20) @(posedge clk);
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'h14) begin
            bad++; $display("FAIL frame_err_status: got=%h want 00000014", r);
        end
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'h4) begin
            bad++; $display("FAIL frame_err_clear: got=%h want 00000004", r);
        end
        bus_xfer(A_DATA, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'd0) begin
            bad++; $display("FAIL frame_err_nopush: got=%h want 00000000", r);
        end
        @(posedge clk); #1;
        rx_drv = 1'b0;
        @(posedge clk); #1;
        rx_drv = 1'b1;
        repeat (60) @(posedge clk);
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'h4) begin
            bad++; $display("FAIL glitch_status: got=%h want 00000004", r);
        end
    endtask

    task automatic test_reset_mid_tx;
        logic [31:0] r; bit acked; bit found;
        bus_xfer(A_DATA, 32'h0000_0000, 4'b0001, r, acked);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (tx === 1'b0) begin found = 1; break; end
        end
        repeat (10) @(posedge clk);
        #1;
        total++; if (!found || tx !== 1'b0) begin
            bad++; $display("FAIL mid_tx_low: found=%0d tx=%b want 1 0", found, tx);
        end
        rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1) begin
            bad++; $display("FAIL reset_tx_async: tx=%b want 1", tx);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus_xfer(A_STAT, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'h4) begin
            bad++; $display("FAIL post_reset_status: got=%h want 00000004", r);
        end
        bus_xfer(A_BAUD, 32'd0, 4'd0, r, acked);
        total++; if (r !== 32'd868 || tx !== 1'b1) begin
            bad++; $display("FAIL post_reset_baud: got=%0d tx=%b want 868 1", r, tx);
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_back_to_back();
        test_rx_overrun();
        test_frame_glitch();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
